capture_arbiter: RTL
====================

Name: capture_arbiter

Overview:
- Shares the four-counter operation-tracking datapath between two independent capture requesters.
- Arbitrates round-robin and converts the winning request's op code into a registered one-hot counter enable.
- Acknowledges the winner.
- When the datapath reports full, sequences a multi-cycle clear and holds off all grants until the clear completes.

Parameters:
- CLR_CYCLES, 2, number of consecutive cycles clear is held high per clear sequence (legal range 1..15).
- CW, 4, width of the internal clear-cycle counter (must satisfy 2^CW > CLR_CYCLES).

Ports:
- clock  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 capture request, level, held until acked
- op0  input  2  requester 0 operation code, stable while req0 high
- req1  input  1  requester 1 capture request, level, held until acked
- op1  input  2  requester 1 operation code, stable while req1 high
- full  input  1  datapath tracking-full flag
- ack0  output  1  requester 0 request consumed (one-cycle pulse)
- ack1  output  1  requester 1 request consumed (one-cycle pulse)
- en  output  4  one-hot counter enable to datapath, en[op] of winner
- clear  output  1  datapath clear, high for CLR_CYCLES cycles per sequence
- busy  output  1  high while in CLEAR state

Behaviour:
- Reset: rst_n low asynchronously forces the following; it is effective mid-sequence, with no partial clear completion.
  - state=RUN
  - ack0=ack1=0, en=0, clear=0, busy=0
  - clear counter=0
  - round-robin pointer=favor requester 0
- All outputs are registered. Response latency is 1 cycle from the sampling edge.
- States: RUN, CLEAR.
- RUN, full=1 at an edge:
  - No grant.
  - Next state CLEAR, counter loaded with CLR_CYCLES-1.
  - clear=1 and busy=1 from the following cycle.
- RUN, full=0:
  - Eligible requester = reqN high AND ackN currently low. A requester is masked in the cycle its ack is asserted, which prevents double counting of a held request.
  - One eligible requester: it wins.
  - Both eligible: the pointer's favored requester wins. The pointer then flips to favor the other requester.
  - The pointer changes only on a contested grant, or on a single grant to the favored side; it always points away from the last winner.
  - Next cycle: ackN=1 for the winner only, and en = one-hot of opN (00->0001, 01->0010, 10->0100, 11->1000).
  - No winner: en=0, acks=0.
- CLEAR:
  - clear=1, busy=1, en=0, acks=0. full and requests are ignored; requests simply wait.
  - Counter decrements each cycle. On the cycle the counter is 0, next state is RUN.
  - clear is high for exactly CLR_CYCLES cycles. Grants resume from the first RUN edge, so the first en appears one cycle after clear drops.
- Invariants:
  - en is zero or one-hot.
  - At most one ack is high.
  - clear and en are never simultaneously nonzero.
  - ackN is never high on two consecutive cycles.
- Simultaneous full=1 with requests in RUN: full wins, requests are not acked and remain pending.
- A request that loses arbitration stays pending with no timeout. Maximum wait under continuous contention is 1 grant slot.

Test Plan:
- Reset then single request: req0=1, op0=10, full=0 -> next cycle en=0100, ack0=1, ack1=0. With req0 still held, the following cycle has en=0000 (masked). The cycle after that regrants if req0 is still high.
- Contention: req0=req1=1 continuously, op0=00, op1=11 -> grants alternate with en sequence 0001,1000,0001,1000 every cycle starting from requester 0, and acks alternate to match.
- Full with CLR_CYCLES=2: raise full for 1 cycle while req1=1 -> clear=1 and busy=1 for exactly 2 cycles, en=0 and ack1=0 throughout. The first cycle after clear drops: en=0000. The next cycle: en=one-hot(op1), ack1=1.
- Full held high across the whole clear -> a single CLR_CYCLES sequence, then one RUN cycle sampling full=1, which starts a new sequence. No grant leaks between the two sequences.
- Async reset mid-CLEAR: drop rst_n between clock edges in the second clear cycle -> clear, busy, en and acks go low immediately. After release, state is RUN and the pointer favors requester 0.
- Sweep all 4 op values on each requester -> en matches the one-hot mapping. Assert the invariants (en one-hot/zero, never both acks, never en with clear) every cycle under random req/full stimulus.

Source files
------------

// File: rtl/capture_arbiter_if.sv
// Capture handshake bundle between two requesters, the datapath flags and the arbiter.
// The master side drives requests and the full flag. The slave side (the arbiter)
// returns acks, the counter enable and the clear status.
interface capture_arbiter_if;
    logic       req0;
    logic [1:0] op0;
    logic       req1;
    logic [1:0] op1;
    logic       full;
    logic       ack0;
    logic       ack1;
    logic [3:0] en;
    logic       clear;
    logic       busy;

    modport master (
        output req0, op0, req1, op1, full,
        input  ack0, ack1, en, clear, busy
    );

    modport slave (
        input  req0, op0, req1, op1, full,
        output ack0, ack1, en, clear, busy
    );
endinterface

// File: rtl/capture_arbiter.sv
// Round-robin arbiter that shares the four-counter tracking datapath between two
// capture requesters. The winning op code becomes a registered one-hot counter enable.
// When the datapath reports full, a clear is held for CLR_CYCLES cycles, and grants
// are held off until that clear completes.
module capture_arbiter #(
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned CW         = 4
) (
    input logic              clock,
    input logic              rst_n,
    capture_arbiter_if.slave bus
);

    typedef enum logic [0:0] {StRun, StClear} state_t;

    state_t        state_q;
    logic [CW-1:0] clr_cnt_q;
    logic          ptr_q;      // 0: requester 0 favoured on contention
    logic          ack0_q;
    logic          ack1_q;
    logic [3:0]    en_q;
    logic          clear_q;
    logic          busy_q;

    logic          elig0;
    logic          elig1;
    logic          win0;
    logic          win1;

    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        op_onehot = 4'b0001 << op;
    endfunction

    // Eligibility masks a requester while its ack is high, so a held request is not
    // counted twice. The pointer resolves contention.
    always_comb begin
        elig0 = bus.req0 & ~ack0_q;
        elig1 = bus.req1 & ~ack1_q;
        win0  = elig0 & (~elig1 | ~ptr_q);
        win1  = elig1 & (~elig0 |  ptr_q);
    end

    // Control FSM with registered outputs. Acks and enable default to idle every cycle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            clr_cnt_q <= '0;
            ptr_q     <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            en_q      <= 4'b0000;
            clear_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            en_q   <= 4'b0000;
            unique case (state_q)
                StRun: begin
                    if (bus.full) begin
                        // full outranks any pending request; requests keep waiting
                        state_q   <= StClear;
                        clr_cnt_q <= CW'(CLR_CYCLES - 1);
                        clear_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (win0) begin
                        ack0_q <= 1'b1;
                        en_q   <= op_onehot(bus.op0);
                        ptr_q  <= 1'b1;
                    end else if (win1) begin
                        ack1_q <= 1'b1;
                        en_q   <= op_onehot(bus.op1);
                        ptr_q  <= 1'b0;
                    end
                end
                StClear: begin
                    if (clr_cnt_q == '0) begin
                        state_q <= StRun;
                        clear_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q - 1'b1;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.en    = en_q;
    assign bus.clear = clear_q;
    assign bus.busy  = busy_q;

endmodule
